// File: rtl/vote_pkg.sv
// Shared types and width helpers for the multi-button vote qualifier.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNT    = 2'd1,
      FIRE     = 2'd2,
      WAIT_REL = 2'd3
   } ch_state_e;

   function automatic int cnt_w(input int hold, input int rel);
      return $clog2(((hold > rel) ? hold : rel) + 1);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One candidate channel: qualifies a held press, emits a one-cycle FIRE state,
// then waits for a sustained release before re-arming.
module button_channel
   import vote_pkg::*;
#(
   parameter int HOLD_CYCLES    = 10,
   parameter int RELEASE_CYCLES = 4,
   parameter int CNT_W          = cnt_w(HOLD_CYCLES, RELEASE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic enable_i,
   input  logic btn_i,
   output logic fire_o,
   output logic idle_o
);

   localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYCLES - 1);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_REL;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!enable_i) begin
         state_d = WAIT_REL;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (btn_i) begin
                  state_d = COUNT;
                  cnt_d   = CNT_W'(1);
               end else begin
                  cnt_d = '0;
               end
            end
            COUNT: begin
               // A fully counted press fires even if the button drops on this edge.
               if (cnt_q >= HOLD_C) begin
                  state_d = FIRE;
                  cnt_d   = '0;
               end else if (!btn_i) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            FIRE: begin
               state_d = WAIT_REL;
               cnt_d   = '0;
            end
            default: begin
               if (btn_i) begin
                  cnt_d = '0;
               end else if (cnt_q >= REL_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   assign fire_o = (state_q == FIRE);
   assign idle_o = (state_q == IDLE);

endmodule

// File: rtl/multi_button_control.sv
// Multi-channel vote qualifier: one button_channel per candidate, plus the
// global accept/conflict decision and registered vote outputs.
module multi_button_control
   import vote_pkg::*;
#(
   parameter int  NUM_BUTTONS    = 4,
   parameter int  HOLD_CYCLES    = 10,
   parameter int  RELEASE_CYCLES = 4,
   localparam int IDX_W          = idx_w(NUM_BUTTONS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_BUTTONS-1:0] button,
   output logic                   valid_vote,
   output logic [IDX_W-1:0]       vote_idx,
   output logic [NUM_BUTTONS-1:0] vote_sel,
   output logic                   conflict,
   output logic                   busy
);

   localparam int CNT_W = cnt_w(HOLD_CYCLES, RELEASE_CYCLES);

   logic [NUM_BUTTONS-1:0] fire, idle;
   logic [IDX_W-1:0]       fire_idx;
   logic                   multi_fire, others_active, vote_ok;

   logic                   valid_q, valid_d, conflict_q, conflict_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_BUTTONS-1:0] sel_q, sel_d;

   for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
      button_channel #(
         .HOLD_CYCLES    (HOLD_CYCLES),
         .RELEASE_CYCLES (RELEASE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .enable_i (enable),
         .btn_i    (button[g]),
         .fire_o   (fire[g]),
         .idle_o   (idle[g])
      );
   end

   always_comb begin
      fire_idx = '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
         if (fire[i]) fire_idx = IDX_W'(i);
      end
   end

   // More than one bit set iff clearing the lowest set bit leaves something.
   assign multi_fire    = |(fire & (fire - NUM_BUTTONS'(1)));
   assign others_active = |(button & ~fire);
   assign vote_ok       = (|fire) && !multi_fire && !others_active;

   always_comb begin
      valid_d    = 1'b0;
      conflict_d = 1'b0;
      idx_d      = '0;
      sel_d      = '0;
      if (enable && (|fire)) begin
         if (vote_ok) begin
            valid_d = 1'b1;
            idx_d   = fire_idx;
            sel_d   = fire;
         end else begin
            conflict_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         conflict_q <= 1'b0;
         idx_q      <= '0;
         sel_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         conflict_q <= conflict_d;
         idx_q      <= idx_d;
         sel_q      <= sel_d;
      end
   end

   assign valid_vote = valid_q;
   assign conflict   = conflict_q;
   assign vote_idx   = idx_q;
   assign vote_sel   = sel_q;
   assign busy       = ~&idle;

endmodule

// File: tb/tb_multi_button_control.sv
// Directed and random stimulus against a run-length model of the vote rules.
module tb_multi_button_control;

   localparam int N = 4;
   localparam int H = 10;
   localparam int R = 4;

   logic         clk = 1'b0;
   logic         reset, enable;
   logic [N-1:0] button;
   logic         valid_vote, conflict, busy;
   logic [1:0]   vote_idx;
   logic [N-1:0] vote_sel;

   always #5 clk = ~clk;

   multi_button_control #(
      .NUM_BUTTONS    (N),
      .HOLD_CYCLES    (H),
      .RELEASE_CYCLES (R)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .button     (button),
      .valid_vote (valid_vote),
      .vote_idx   (vote_idx),
      .vote_sel   (vote_sel),
      .conflict   (conflict),
      .busy       (busy)
   );

   int vectors = 0, miscompares = 0;

   // Model: an armed channel counts consecutive highs; a disarmed one counts
   // consecutive lows; a pending fire is resolved on the following edge.
   bit           m_armed[N];
   bit           m_fire[N];
   int           m_run[N];
   int           m_rel[N];
   logic         ev, ec, eb;
   logic [1:0]   eidx;
   logic [N-1:0] esel;

   int nv, nc, last_idx, vote_step, stepno;
   logic [N-1:0] last_sel;

   function automatic void model_edge(input logic r, input logic e, input logic [N-1:0] b);
      int  nf, fi;
      bit  others;
      nf = 0; fi = 0; others = 0;
      ev = 0; ec = 0; eidx = '0; esel = '0;
      if (r || !e) begin
         for (int i = 0; i < N; i++) begin
            m_armed[i] = 0; m_fire[i] = 0; m_run[i] = 0; m_rel[i] = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m_fire[i]) begin nf++; fi = i; end
            else if (b[i]) others = 1;
         end
         if (nf == 1 && !others) begin
            ev = 1; eidx = 2'(fi); esel = N'(1) << fi;
         end else if (nf > 0) begin
            ec = 1;
         end
         for (int i = 0; i < N; i++) begin
            if (m_fire[i]) begin
               m_fire[i] = 0; m_armed[i] = 0; m_rel[i] = 0;
            end else if (m_armed[i]) begin
               if (m_run[i] == H) begin
                  m_fire[i] = 1; m_armed[i] = 0; m_run[i] = 0;
               end else if (b[i]) m_run[i]++;
               else m_run[i] = 0;
            end else begin
               if (b[i]) m_rel[i] = 0;
               else m_rel[i]++;
               if (m_rel[i] == R) begin
                  m_armed[i] = 1; m_run[i] = 0; m_rel[i] = 0;
               end
            end
         end
      end
      eb = 0;
      for (int i = 0; i < N; i++)
         if (!(m_armed[i] && m_run[i] == 0)) eb = 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [N-1:0] b);
      reset = r; enable = e; button = b;
      @(posedge clk);
      model_edge(r, e, b);
      #1;
      stepno++;
      chk("valid_vote", 32'(valid_vote), 32'(ev));
      chk("vote_idx",   32'(vote_idx),   32'(eidx));
      chk("vote_sel",   32'(vote_sel),   32'(esel));
      chk("conflict",   32'(conflict),   32'(ec));
      chk("busy",       32'(busy),       32'(eb));
      if (valid_vote === 1'b1) begin
         nv++; last_idx = int'(vote_idx); last_sel = vote_sel; vote_step = stepno;
      end
      if (conflict === 1'b1) nc++;
   endtask

   task automatic hold(input int n, input logic [N-1:0] b, input logic e = 1'b1);
      repeat (n) step(1'b0, e, b);
   endtask

   task automatic clr();
      nv = 0; nc = 0; stepno = 0; vote_step = -1; last_idx = -1; last_sel = '0;
   endtask

   initial begin
      logic [N-1:0] rb;
      logic         re, rr;
      clr();
      reset = 1'b1; enable = 1'b1; button = '0;

      step(1'b1, 1'b1, '0);
      step(1'b1, 1'b1, '0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_valid", 32'(valid_vote), 32'd0);
      hold(R, '0);
      chk("idle_busy", 32'(busy), 32'd0);

      // single press on channel 2
      clr();
      hold(15, 4'b0100);
      chk("t1_votes", 32'(nv), 32'd1);
      chk("t1_latency", 32'(vote_step), 32'd12);
      chk("t1_idx", 32'(last_idx), 32'd2);
      chk("t1_sel", 32'(last_sel), 32'b0100);
      hold(3, '0);
      chk("t1_busy3", 32'(busy), 32'd1);
      hold(1, '0);
      chk("t1_busy4", 32'(busy), 32'd0);

      // short press with glitch
      clr();
      hold(9, 4'b0010); hold(1, '0); hold(9, 4'b0010); hold(R, '0);
      chk("t2_votes", 32'(nv), 32'd0);
      chk("t2_conf", 32'(nc), 32'd0);

      // simultaneous press
      clr();
      hold(30, 4'b1001);
      chk("t3_votes", 32'(nv), 32'd0);
      chk("t3_conf", 32'(nc), 32'd1);
      hold(R, '0);

      // overlapping press, then clean press on channel 2
      clr();
      hold(5, 4'b0010); hold(15, 4'b0110);
      chk("t4_votes", 32'(nv), 32'd0);
      chk("t4_conf", 32'(nc > 0), 32'd1);
      hold(R, '0);
      clr();
      hold(12, 4'b0100);
      chk("t4_votes2", 32'(nv), 32'd1);
      chk("t4_idx2", 32'(last_idx), 32'd2);
      hold(R, '0);

      // re-arm requires a full release
      clr();
      hold(30, 4'b0001);
      chk("t5_one", 32'(nv), 32'd1);
      hold(3, '0); hold(12, 4'b0001);
      chk("t5_short_rel", 32'(nv), 32'd1);
      hold(4, '0); hold(12, 4'b0001);
      chk("t5_rearm", 32'(nv), 32'd2);
      chk("t5_idx", 32'(last_idx), 32'd0);
      hold(R, '0);

      // button stuck through reset
      clr();
      step(1'b1, 1'b1, 4'b1000); step(1'b1, 1'b1, 4'b1000);
      hold(15, 4'b1000);
      chk("t6_stuck", 32'(nv), 32'd0);
      hold(R, '0); hold(12, 4'b1000);
      chk("t6_after_rel", 32'(nv), 32'd1);
      hold(R, '0);

      // reset during COUNT
      clr();
      hold(5, 4'b1000);
      step(1'b1, 1'b1, 4'b1000);
      chk("t6_rst_valid", 32'(valid_vote), 32'd0);
      chk("t6_rst_conf", 32'(conflict), 32'd0);
      chk("t6_rst_sel", 32'(vote_sel), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd1);
      hold(15, 4'b1000);
      chk("t6_rst_votes", 32'(nv), 32'd0);
      hold(R, '0);

      // enable low during a press
      clr();
      hold(15, 4'b1000, 1'b0);
      hold(R, '0);
      hold(5, 4'b1000); hold(2, 4'b1000, 1'b0); hold(10, 4'b1000);
      chk("t6_enable", 32'(nv), 32'd0);
      chk("t6_enable_conf", 32'(nc), 32'd0);
      hold(R, '0);

      // random: sticky presses, rare enable drops and resets
      rb = '0;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < N; i++) begin
            if (rb[i]) rb[i] = ($urandom_range(11) != 0);
            else       rb[i] = ($urandom_range(29) == 0);
         end
         re = ($urandom_range(99) != 0);
         rr = ($urandom_range(499) == 0);
         step(rr, re, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
